// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_ctrl
// Brief    : Fetch-stage PC sequencing. Selects between exception redirect,
//            branch redirect (held across stalls) and PC+4 advance. Issues
//            bounded outstanding fetches and drops returns from flushed paths.
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_stall,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        br_req,
  input  logic [31:0] br_target,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        fetch_rvalid,
  output logic        inst_valid,
  output logic        pc_wen,
  output logic        PC_exc_sel,
  output logic        PC_target_sel,
  output logic [31:0] PC_exc_o,
  output logic [31:0] PC_target_o,
  output logic        busy
);

  localparam logic [CNT_W-1:0] c_MAX_OUT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] c_ZERO    = '0;
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] r_disc_cnt;
  logic             r_pend_valid;
  logic [31:0]      r_pend_pc;

  logic             w_exc_apply;
  logic             w_br_valid;
  logic [31:0]      w_br_src;
  logic             w_br_apply;
  logic             w_redirect;
  logic             w_room;
  logic             w_accept;
  logic             w_out_nz;
  logic             w_ret;
  logic [CNT_W-1:0] w_accept_inc;
  logic [CNT_W-1:0] w_ret_dec;

  // Redirect arbitration: exception first, then a live or held branch.
  // Every output is gated by rst_n so the block is quiet while in reset.
  always_comb begin
    w_exc_apply  = rst_n & exc_req;
    w_br_valid   = br_req | r_pend_valid;
    w_br_src     = br_req ? br_target : r_pend_pc;
    w_br_apply   = rst_n & w_br_valid & ~pipe_stall & ~exc_req;
    w_redirect   = w_exc_apply | w_br_apply;
    w_room       = (r_out_cnt < c_MAX_OUT);
    w_out_nz     = (r_out_cnt != c_ZERO);
    w_ret        = fetch_rvalid & w_out_nz;

    fetch_req    = rst_n & ~pipe_stall & ~w_redirect & w_room;
    w_accept     = fetch_req & fetch_ack;
    w_accept_inc = w_accept ? c_ONE : c_ZERO;
    w_ret_dec    = w_ret ? c_ONE : c_ZERO;

    pc_wen        = w_redirect | w_accept;
    PC_exc_sel    = w_exc_apply;
    PC_target_sel = w_br_apply;
    PC_exc_o      = rst_n ? exc_pc : 32'h0;
    PC_target_o   = rst_n ? w_br_src : 32'h0;
    // A return with nothing outstanding is a protocol error and is never live.
    inst_valid    = rst_n & w_ret & (r_disc_cnt == c_ZERO);
    busy          = rst_n & (w_out_nz | r_pend_valid);
  end

  // Outstanding/discard bookkeeping and the held branch redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_cnt    <= c_ZERO;
      r_disc_cnt   <= c_ZERO;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'h0;
    end else begin
      r_out_cnt <= r_out_cnt + w_accept_inc - w_ret_dec;

      // On a redirect everything still in flight (minus this cycle's return,
      // which was already judged against the old discard count) is stale.
      if (w_redirect) begin
        r_disc_cnt <= r_out_cnt - w_ret_dec;
      end else if (fetch_rvalid && (r_disc_cnt != c_ZERO)) begin
        r_disc_cnt <= r_disc_cnt - c_ONE;
      end

      // A redirect consumes the pending branch; an unapplied branch is held,
      // newer requests overwriting older ones.
      if (w_redirect) begin
        r_pend_valid <= 1'b0;
      end else if (br_req) begin
        r_pend_valid <= 1'b1;
        r_pend_pc    <= br_target;
      end
    end
  end

endmodule
`default_nettype wire
